// File: rtl/platform_pio_gpio_irq.sv
// Avalon-MM parallel I/O block: output data/direction registers, set/clear aliases,
// synchronised pin inputs with edge capture and a masked level interrupt.
module platform_pio_gpio_irq #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] dly_q, dly_d;
    logic [1:0]       arm_q, arm_d;

    logic             wr_en;
    logic             armed;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_hit;
    logic [31:0]      rd_w;
    logic             wd_unused;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign armed     = (arm_q == 2'd3);
    assign wd_unused = ^writedata;

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        mask_d  = mask_q;
        clr     = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   out_d  = wd;
                ADDR_DIR:    oe_d   = wd;
                ADDR_MASK:   mask_d = wd;
                ADDR_EDGE:   clr    = wd;
                ADDR_OUTSET: out_d  = out_q | wd;
                ADDR_OUTCLR: out_d  = out_q & ~wd;
                default:     ;
            endcase
        end
    end

    // Edge compares the synchroniser output with its one-cycle-delayed copy.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        arm_d   = armed ? arm_q : arm_q + 2'd1;
        if (EDGE_TYPE == 0)
            edge_hit = sync2_q & ~dly_q;
        else if (EDGE_TYPE == 1)
            edge_hit = ~sync2_q & dly_q;
        else
            edge_hit = sync2_q ^ dly_q;
        // A new edge wins over a same-cycle write-1-to-clear.
        cap_d = (cap_q & ~clr) | (armed ? edge_hit : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_VALUE;
            oe_q    <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
            arm_q   <= '0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            arm_q   <= arm_d;
        end
    end

    always_comb begin
        rd_w = '0;
        case (address)
            ADDR_DATA: rd_w[WIDTH-1:0] = (out_q & oe_q) | (sync2_q & ~oe_q);
            ADDR_DIR:  rd_w[WIDTH-1:0] = oe_q;
            ADDR_MASK: rd_w[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_w[WIDTH-1:0] = cap_q;
            default:   rd_w = '0;
        endcase
    end

    assign readdata = rd_w;
    assign out_port = out_q;
    assign oe       = oe_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_platform_pio_gpio_irq.sv
// Directed bench for platform_pio_gpio_irq: a rising-edge instance and an any-edge
// instance with a non-zero reset value share the bus, each with its own pins.
module tb_platform_pio_gpio_irq;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port0, in_port2;
    logic [31:0] rd0, rd2;
    logic [9:0]  out0, out2, oe0, oe2;
    logic        irq0, irq2;

    int vec_cnt = 0;
    int err_cnt = 0;

    platform_pio_gpio_irq #(.WIDTH(10), .RESET_VALUE(10'h000), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port0), .out_port(out0), .oe(oe0), .irq(irq0)
    );

    platform_pio_gpio_irq #(.WIDTH(10), .RESET_VALUE(10'h2A5), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port2), .out_port(out2), .oe(oe2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        #12;
        vec_cnt++; if (out0 !== 10'h000) begin err_cnt++; $display("FAIL rst_out0 got %h exp %h", out0, 10'h000); end
        vec_cnt++; if (out2 !== 10'h2A5) begin err_cnt++; $display("FAIL rst_out2 got %h exp %h", out2, 10'h2A5); end
        vec_cnt++; if (oe0 !== 10'h000) begin err_cnt++; $display("FAIL rst_oe0 got %h exp %h", oe0, 10'h000); end
        vec_cnt++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin err_cnt++; $display("FAIL rst_irq got %b%b exp 00", irq0, irq2); end
        rd(3'd0);
        vec_cnt++; if (rd2 !== 32'h0) begin err_cnt++; $display("FAIL rst_rd_data got %h exp %h", rd2, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_data;
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h3FF);
        wr(3'd5, 32'h00F);
        vec_cnt++; if (out0 !== 10'h3F0) begin err_cnt++; $display("FAIL outclr got %h exp %h", out0, 10'h3F0); end
        rd(3'd0);
        vec_cnt++; if (rd0 !== 32'h3F0) begin err_cnt++; $display("FAIL rd_data got %h exp %h", rd0, 32'h3F0); end
        rd(3'd1);
        vec_cnt++; if (rd0 !== 32'h3FF) begin err_cnt++; $display("FAIL rd_dir got %h exp %h", rd0, 32'h3FF); end
        wr(3'd4, 32'h005);
        vec_cnt++; if (out0 !== 10'h3F5) begin err_cnt++; $display("FAIL outset got %h exp %h", out0, 10'h3F5); end
        for (int a = 4; a < 8; a++) begin
            rd(3'(a));
            vec_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL rd_zero_addr%0d got %h exp %h", a, rd0, 32'h0); end
        end
        wr(3'd6, 32'h3FF);
        vec_cnt++; if (out0 !== 10'h3F5 || oe0 !== 10'h3FF) begin err_cnt++; $display("FAIL rsvd_wr got %h/%h exp 3f5/3ff", out0, oe0); end
        wr(3'd0, 32'hFFFF_FC0A);
        rd(3'd0);
        vec_cnt++; if (rd0 !== 32'h0000_000A) begin err_cnt++; $display("FAIL wd_upper got %h exp %h", rd0, 32'h0000_000A); end
        wr(3'd0, 32'h3F5);
        wr(3'd1, 32'h0F0);
        in_port0 = 10'h155;
        repeat (3) @(negedge clk);
        rd(3'd0);
        vec_cnt++; if (rd0 !== 32'h1F5) begin err_cnt++; $display("FAIL rd_mixed got %h exp %h", rd0, 32'h1F5); end
    endtask

    task automatic test_edge;
        in_port0 = 10'h000;
        repeat (4) @(negedge clk);
        wr(3'd3, 32'h3FF);
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL cap_clear_all got %h exp %h", rd0, 32'h0); end
        wr(3'd2, 32'h001);
        rd(3'd2);
        vec_cnt++; if (rd0 !== 32'h001) begin err_cnt++; $display("FAIL rd_mask got %h exp %h", rd0, 32'h001); end
        @(negedge clk);
        in_port0 = 10'h001;
        @(negedge clk);
        @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h0 || irq0 !== 1'b0) begin err_cnt++; $display("FAIL cap_early got %h/%b exp 0/0", rd0, irq0); end
        @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h001 || irq0 !== 1'b1) begin err_cnt++; $display("FAIL cap_3rd_edge got %h/%b exp 1/1", rd0, irq0); end
        wr(3'd3, 32'h001);
        vec_cnt++; if (irq0 !== 1'b0) begin err_cnt++; $display("FAIL w1c_irq got %b exp 0", irq0); end
        in_port0 = 10'h000;
        repeat (4) @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL fall_ignored got %h exp %h", rd0, 32'h0); end
    endtask

    task automatic test_simul;
        @(negedge clk);
        in_port0 = 10'h001;
        @(negedge clk);
        @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h001;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h001 || irq0 !== 1'b1) begin err_cnt++; $display("FAIL edge_vs_clr got %h/%b exp 1/1", rd0, irq0); end
        wr(3'd3, 32'h001);
        rd(3'd3);
        vec_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL clr_after got %h exp %h", rd0, 32'h0); end
    endtask

    task automatic test_reset_hold;
        @(negedge clk);
        reset    = 1'b1;
        in_port0 = 10'h3FF;
        in_port2 = 10'h3FF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd(3'd3);
            vec_cnt++;
            if (rd0 !== 32'h0 || rd2 !== 32'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
                err_cnt++; $display("FAIL arm_hold_c%0d got %h/%h irq %b%b exp 0/0 irq 00", i, rd0, rd2, irq0, irq2);
            end
        end
        wr(3'd2, 32'h3FF);
        vec_cnt++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin err_cnt++; $display("FAIL arm_hold_irq got %b%b exp 00", irq0, irq2); end
    endtask

    task automatic test_any_edge;
        wr(3'd2, 32'h000);
        in_port2 = 10'h000;
        repeat (4) @(negedge clk);
        wr(3'd3, 32'h3FF);
        rd(3'd3);
        vec_cnt++; if (rd2 !== 32'h0) begin err_cnt++; $display("FAIL any_clear got %h exp %h", rd2, 32'h0); end
        @(negedge clk);
        in_port2 = 10'h008;
        repeat (5) @(negedge clk);
        in_port2 = 10'h000;
        repeat (5) @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd2 !== 32'h008 || irq2 !== 1'b0) begin err_cnt++; $display("FAIL any_pulse got %h/%b exp 8/0", rd2, irq2); end
        wr(3'd3, 32'h008);
        in_port2 = 10'h008;
        repeat (4) @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd2 !== 32'h008) begin err_cnt++; $display("FAIL any_rise got %h exp %h", rd2, 32'h008); end
        wr(3'd3, 32'h008);
        rd(3'd3);
        vec_cnt++; if (rd2 !== 32'h0) begin err_cnt++; $display("FAIL any_w1c got %h exp %h", rd2, 32'h0); end
        in_port2 = 10'h000;
        repeat (4) @(negedge clk);
        rd(3'd3);
        vec_cnt++; if (rd2 !== 32'h008) begin err_cnt++; $display("FAIL any_fall got %h exp %h", rd2, 32'h008); end
        wr(3'd2, 32'h008);
        vec_cnt++; if (irq2 !== 1'b1 || irq0 !== 1'b0) begin err_cnt++; $display("FAIL mask_irq got %b%b exp 01", irq0, irq2); end
    endtask

    task automatic test_async_reset;
        wr(3'd1, 32'h155);
        wr(3'd0, 32'h3FF);
        vec_cnt++; if (oe0 !== 10'h155 || irq2 !== 1'b1) begin err_cnt++; $display("FAIL pre_rst got %h/%b exp 155/1", oe0, irq2); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++; if (oe0 !== 10'h000 || oe2 !== 10'h000) begin err_cnt++; $display("FAIL async_oe got %h/%h exp 0/0", oe0, oe2); end
        vec_cnt++; if (out0 !== 10'h000 || out2 !== 10'h2A5) begin err_cnt++; $display("FAIL async_out got %h/%h exp 000/2a5", out0, out2); end
        vec_cnt++; if (irq2 !== 1'b0) begin err_cnt++; $display("FAIL async_irq got %b exp 0", irq2); end
        rd(3'd1);
        vec_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL async_rd_dir got %h exp %h", rd0, 32'h0); end
        rd(3'd0);
        vec_cnt++; if (rd2 !== 32'h0) begin err_cnt++; $display("FAIL async_rd_data got %h exp %h", rd2, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port0   = 10'h000;
        in_port2   = 10'h000;
        test_reset;
        test_data;
        test_edge;
        test_simul;
        test_reset_hold;
        test_any_edge;
        test_async_reset;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
